weight_load_sequencer: RTL
==========================

Name: weight_load_sequencer

Overview:
- Sequences filter-weight loading from a 32-bit input stream into the 5-row weight buffer, one (filter m, input channel c) slice at a time.
- Computes the per-slice word count from the filter geometry and drives the buffer write port.
- Waits for buffer FULL, starts the MAC array, and holds the next load until compute completes.
- Sits between the DMA weight stream and the weight buffer / conv compute core.

Parameters:
- INPUT_WIDTH, 32, stream and buffer write-data width.
- CNT_WIDTH, 10, width of the channel and filter counters.

Ports:
- CLK  in  1  clock
- RESETN  in  1  synchronous active-low reset
- START  in  1  one-cycle pulse; latches config and begins a job
- SOFT_CLR  in  1  abort the job and return to IDLE
- PARAM_R  in  4  filter height
- PARAM_S  in  4  filter width
- PARAM_C  in  CNT_WIDTH  input channels per filter
- PARAM_M  in  CNT_WIDTH  number of filters
- S_TDATA  in  INPUT_WIDTH  weight stream data
- S_TVALID  in  1  stream valid
- S_TREADY  out  1  stream ready
- WB_WR_EN  out  1  buffer write enable
- WB_WR_VALID  out  1  buffer write valid
- WB_WR_DATA  out  INPUT_WIDTH  buffer write data
- WB_PARAM_R  out  4  latched R to buffer
- WB_PARAM_S  out  4  latched S to buffer
- WB_FULL  in  1  buffer slice complete
- COMP_START  out  1  one-cycle compute start pulse
- COMP_DONE  in  1  compute finished with current slice
- CUR_C  out  CNT_WIDTH  channel index of the current slice
- CUR_M  out  CNT_WIDTH  filter index of the current slice
- BUSY  out  1  job in progress
- DONE  out  1  one-cycle job-complete pulse
- CFG_ERR  out  1  sticky; last START rejected

Behaviour:
- Reset values: every output is 0 and the state is IDLE.
- Reset mid-job drops all progress. The system must reset the buffer in the same cycle.

Config latching (START seen in IDLE):
- Latch R, S, C, M into registers.
- WB_PARAM_R and WB_PARAM_S are driven from these registers only, so they stay stable for the whole job.
- Rejection: if R or S is outside 1..5, or C=0 or M=0, stay in IDLE and set CFG_ERR.
- Otherwise clear CFG_ERR and go to LOAD.
- START outside IDLE is ignored.

Words per slice:
- W = 7 if S=5 (five 40-bit rows packed into 224 bits).
- Otherwise W = R (one word per row).
- The word counter is 3 bits.

States:
- IDLE: BUSY=0.
- LOAD:
  - S_TREADY=1 and WB_WR_EN=1.
  - WB_WR_VALID = S_TVALID; WB_WR_DATA = S_TDATA (combinational pass-through).
  - A transfer is S_TVALID & S_TREADY and increments word_cnt.
  - On the transfer with word_cnt=W-1: clear word_cnt and go to WAIT_FULL.
  - TVALID gaps are allowed and stall the load without penalty.
- WAIT_FULL:
  - S_TREADY=0 and WB_WR_EN=0.
  - WB_FULL is registered in the buffer, so it rises the cycle after the last write. FULL left over from the previous slice can never be sampled here, because the buffer clears it on the first write.
  - When WB_FULL=1: pulse COMP_START for 1 cycle and go to COMPUTE.
- COMPUTE:
  - Hold until COMP_DONE, then advance the counters.
  - If c < C-1: c++.
  - Else if m < M-1: c=0, m++.
  - Else go to FIN.
  - Otherwise go to LOAD.
  - COMP_DONE in any other state is ignored.
- FIN: pulse DONE for 1 cycle, then go to IDLE.

Status and timing:
- CUR_C and CUR_M show the slice currently loading or computing.
- BUSY=1 in all states except IDLE.
- Minimum slice turnaround (last write to COMP_START) is 2 cycles.
- SOFT_CLR: from any state, return to IDLE on the next edge and clear counters; CFG_ERR is kept. SOFT_CLR takes priority over START.

Optional Feature:
- Macro: WEIGHT_SEQ_PERF_EN.
- When defined:
  - Adds outputs STALL_CNT[31:0] and COMPUTE_CNT[31:0].
  - STALL_CNT counts cycles spent in LOAD with S_TVALID=0.
  - COMPUTE_CNT counts cycles spent in COMPUTE.
  - Both clear on an accepted START and saturate at all-ones.
- When undefined: no counters and no extra ports.

Decomposition:
- Shared package weight_seq_pkg holds:
  - the state enum (IDLE, LOAD, WAIT_FULL, COMPUTE, FIN);
  - MAX_FILTER_DIM=5;
  - WORDS_PACKED_5WIDE=7;
  - function words_per_slice(R,S).
- Sub-module weight_slice_counter: nested c/m counter with advance input and last flag. It is reused later for the input-feature sequencer.

Test Plan:
- R=3, S=3, C=2, M=2, TVALID always high → 12 writes in four bursts of 3; COMP_START after each burst once FULL; CUR_C/CUR_M sequence 0/0, 1/0, 0/1, 1/1; DONE pulses once.
- R=5, S=5, C=1, M=1 → exactly 7 writes, COMP_START 2 cycles after the 7th write, DONE one cycle after COMP_DONE.
- R=6, S=3 START → CFG_ERR=1, BUSY stays 0, S_TREADY stays 0. A following valid START clears CFG_ERR.
- R=2, S=4 with TVALID toggling every other cycle → 2 writes accepted; stall cycles do not advance word_cnt; with WEIGHT_SEQ_PERF_EN, STALL_CNT equals the number of low-TVALID cycles.
- SOFT_CLR asserted mid-LOAD after word 1 of 3 → IDLE next cycle, BUSY=0. A new START reloads from word 0 with c=m=0.
- COMP_DONE pulsed during LOAD, and START pulsed during COMPUTE → both ignored; counters and state unchanged.

Source files
------------

// File: rtl/weight_seq_pkg.sv
// Shared types and helpers for the weight-load sequencer.
package weight_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitFull,
    StCompute,
    StFin
  } seq_state_e;

  localparam int unsigned MAX_FILTER_DIM     = 5;
  localparam int unsigned WORDS_PACKED_5WIDE = 7;

  // Five 40-bit rows of a 5-wide filter pack into seven 32-bit words;
  // narrower filters use one word per row.
  function automatic logic [2:0] words_per_slice(input logic [3:0] r, input logic [3:0] s);
    logic [2:0] w;
    if (s == 4'(MAX_FILTER_DIM)) w = 3'(WORDS_PACKED_5WIDE);
    else                         w = 3'(r);
    return w;
  endfunction

endpackage

// File: rtl/weight_load_sequencer_if.sv
// Weight stream in / weight-buffer write port bundle.
interface weight_load_sequencer_if #(
  parameter int unsigned INPUT_WIDTH = 32
);
  logic [INPUT_WIDTH-1:0] S_TDATA;
  logic                   S_TVALID;
  logic                   S_TREADY;
  logic                   WB_WR_EN;
  logic                   WB_WR_VALID;
  logic [INPUT_WIDTH-1:0] WB_WR_DATA;
  logic                   WB_FULL;

  modport master (
    input  S_TDATA, S_TVALID, WB_FULL,
    output S_TREADY, WB_WR_EN, WB_WR_VALID, WB_WR_DATA
  );

  modport slave (
    output S_TDATA, S_TVALID, WB_FULL,
    input  S_TREADY, WB_WR_EN, WB_WR_VALID, WB_WR_DATA
  );
endinterface

// File: rtl/weight_slice_counter.sv
// Nested channel/filter slice counter: c is the inner index, m the outer.
// Advancing on the final slice wraps both back to zero.
module weight_slice_counter #(
  parameter int unsigned CNT_WIDTH = 10
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 i_clr,
  input  logic                 i_adv,
  input  logic [CNT_WIDTH-1:0] i_cfg_c,
  input  logic [CNT_WIDTH-1:0] i_cfg_m,
  output logic [CNT_WIDTH-1:0] o_cur_c,
  output logic [CNT_WIDTH-1:0] o_cur_m,
  output logic                 o_last
);
  logic [CNT_WIDTH-1:0] r_c, r_m;
  logic                 w_c_last, w_m_last;

  assign w_c_last = (r_c == i_cfg_c - CNT_WIDTH'(1));
  assign w_m_last = (r_m == i_cfg_m - CNT_WIDTH'(1));
  assign o_last   = w_c_last & w_m_last;
  assign o_cur_c  = r_c;
  assign o_cur_m  = r_m;

  // Counter state: clear wins over advance.
  always_ff @(posedge CLK) begin
    if (!RESETN || i_clr) begin
      r_c <= '0;
      r_m <= '0;
    end else if (i_adv) begin
      if (!w_c_last) begin
        r_c <= r_c + CNT_WIDTH'(1);
      end else begin
        r_c <= '0;
        r_m <= w_m_last ? '0 : r_m + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/weight_load_sequencer.sv
// Weight-load sequencer: streams one (m, c) filter slice at a time into the
// weight buffer, starts the MAC array once the buffer is full and waits for
// compute before loading the next slice.
// Optional build macro WEIGHT_SEQ_PERF_EN adds STALL_CNT / COMPUTE_CNT.
module weight_load_sequencer
  import weight_seq_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 10
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 START,
  input  logic                 SOFT_CLR,
  input  logic [3:0]           PARAM_R,
  input  logic [3:0]           PARAM_S,
  input  logic [CNT_WIDTH-1:0] PARAM_C,
  input  logic [CNT_WIDTH-1:0] PARAM_M,
  weight_load_sequencer_if.master wl_bus,
  output logic [3:0]           WB_PARAM_R,
  output logic [3:0]           WB_PARAM_S,
  output logic                 COMP_START,
  input  logic                 COMP_DONE,
  output logic [CNT_WIDTH-1:0] CUR_C,
  output logic [CNT_WIDTH-1:0] CUR_M,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 CFG_ERR
`ifdef WEIGHT_SEQ_PERF_EN
  ,
  output logic [31:0]          STALL_CNT,
  output logic [31:0]          COMPUTE_CNT
`endif
);
  seq_state_e           r_state, w_state_next;
  logic [2:0]           r_word_cnt, w_word_next, w_words;
  logic [3:0]           r_param_r, r_param_s;
  logic [CNT_WIDTH-1:0] r_param_c, r_param_m;
  logic                 r_cfg_err, w_cfg_err_next;
  logic                 r_comp_start, w_comp_start_next;
  logic                 w_latch, w_cnt_clr, w_cnt_adv, w_cnt_last;
  logic                 w_cfg_ok, w_in_load, w_xfer;

  assign w_cfg_ok = (PARAM_R != 4'd0) && (PARAM_R <= 4'(MAX_FILTER_DIM)) &&
                    (PARAM_S != 4'd0) && (PARAM_S <= 4'(MAX_FILTER_DIM)) &&
                    (PARAM_C != '0) && (PARAM_M != '0);
  assign w_words   = words_per_slice(r_param_r, r_param_s);
  assign w_in_load = (r_state == StLoad);
  assign w_xfer    = w_in_load & wl_bus.S_TVALID;

  // Next-state and control decode; SOFT_CLR overrides everything.
  always_comb begin
    w_state_next      = r_state;
    w_word_next       = r_word_cnt;
    w_cfg_err_next    = r_cfg_err;
    w_comp_start_next = 1'b0;
    w_latch           = 1'b0;
    w_cnt_clr         = 1'b0;
    w_cnt_adv         = 1'b0;
    if (SOFT_CLR) begin
      w_state_next = StIdle;
      w_word_next  = 3'd0;
      w_cnt_clr    = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (START) begin
            if (w_cfg_ok) begin
              w_latch        = 1'b1;
              w_cnt_clr      = 1'b1;
              w_cfg_err_next = 1'b0;
              w_word_next    = 3'd0;
              w_state_next   = StLoad;
            end else begin
              w_cfg_err_next = 1'b1;
            end
          end
        end
        StLoad: begin
          if (w_xfer) begin
            if (r_word_cnt == w_words - 3'd1) begin
              w_word_next  = 3'd0;
              w_state_next = StWaitFull;
            end else begin
              w_word_next = r_word_cnt + 3'd1;
            end
          end
        end
        StWaitFull: begin
          if (wl_bus.WB_FULL) begin
            w_comp_start_next = 1'b1;
            w_state_next      = StCompute;
          end
        end
        StCompute: begin
          if (COMP_DONE) begin
            w_cnt_adv    = 1'b1;
            w_state_next = w_cnt_last ? StFin : StLoad;
          end
        end
        StFin:   w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  // State, word counter, sticky error, compute pulse and latched config.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state      <= StIdle;
      r_word_cnt   <= 3'd0;
      r_cfg_err    <= 1'b0;
      r_comp_start <= 1'b0;
      r_param_r    <= 4'd0;
      r_param_s    <= 4'd0;
      r_param_c    <= '0;
      r_param_m    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_word_cnt   <= w_word_next;
      r_cfg_err    <= w_cfg_err_next;
      r_comp_start <= w_comp_start_next;
      if (w_latch) begin
        r_param_r <= PARAM_R;
        r_param_s <= PARAM_S;
        r_param_c <= PARAM_C;
        r_param_m <= PARAM_M;
      end
    end
  end

  weight_slice_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slice_cnt (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .i_clr   (w_cnt_clr),
    .i_adv   (w_cnt_adv),
    .i_cfg_c (r_param_c),
    .i_cfg_m (r_param_m),
    .o_cur_c (CUR_C),
    .o_cur_m (CUR_M),
    .o_last  (w_cnt_last)
  );

  assign wl_bus.S_TREADY    = w_in_load;
  assign wl_bus.WB_WR_EN    = w_in_load;
  assign wl_bus.WB_WR_VALID = w_xfer;
  assign wl_bus.WB_WR_DATA  = w_in_load ? wl_bus.S_TDATA : INPUT_WIDTH'(0);
  assign WB_PARAM_R         = r_param_r;
  assign WB_PARAM_S         = r_param_s;
  assign COMP_START         = r_comp_start;
  assign BUSY               = (r_state != StIdle);
  assign DONE               = (r_state == StFin);
  assign CFG_ERR            = r_cfg_err;

`ifdef WEIGHT_SEQ_PERF_EN
  logic [31:0] r_stall_cnt, r_compute_cnt;

  // Saturating perf counters, cleared by an accepted START.
  always_ff @(posedge CLK) begin
    if (!RESETN || w_latch) begin
      r_stall_cnt   <= '0;
      r_compute_cnt <= '0;
    end else begin
      if (w_in_load && !wl_bus.S_TVALID && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if ((r_state == StCompute) && (r_compute_cnt != '1)) begin
        r_compute_cnt <= r_compute_cnt + 32'd1;
      end
    end
  end

  assign STALL_CNT   = r_stall_cnt;
  assign COMPUTE_CNT = r_compute_cnt;
`endif

endmodule
